// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: button indices and default timing for the five-way button front-end.
package button_conditioner_pkg;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_MID   = 4;
    localparam int BTN_NUM   = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;
endpackage

// File: rtl/button_debounce_cell.sv
// button_debounce_cell: synchroniser, debounce counter, level and press pulse for one button.
// Auto-repeat timer is generated only when BTN_REPEAT_EN is defined.
module button_debounce_cell
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   syncd;
    logic                   done;
    logic                   rpt_hit;

    assign syncd = sync_q[SYNC_STAGES-1];
    assign done  = (syncd != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt    <= (syncd == level || done) ? '0 : cnt + 1'b1;
            level  <= level ^ done;
            press  <= (done & ~level) | rpt_hit;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt;
    logic          rep;

    // rep selects the period once the first delayed repeat has fired
    assign rpt_hit = repeat_en & level & ~done &
                     (rpt_cnt == RW'(rep ? REPEAT_PERIOD - 1 : REPEAT_DELAY - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
            rep     <= 1'b0;
        end else if (!level || done || !repeat_en) begin
            rpt_cnt <= '0;
            rep     <= 1'b0;
        end else if (rpt_hit) begin
            rpt_cnt <= '0;
            rep     <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = repeat_en ^ (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
    assign rpt_hit    = 1'b0;
`endif
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced levels and press pulses for up/down/left/right/mid buttons.
// Define BTN_REPEAT_EN to enable auto-repeat on the four direction buttons.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BTN_NUM-1:0] btn_raw_i,
    output logic [BTN_NUM-1:0] btn_level_o,
    output logic [BTN_NUM-1:0] btn_press_o,
    output logic               mid_button_o
);
    for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
        button_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .raw      (btn_raw_i[i]),
            .repeat_en(i != BTN_MID),
            .level    (btn_level_o[i]),
            .press    (btn_press_o[i])
        );
    end

    // mid never repeats so screen_machine sees one event per physical press
    assign mid_button_o = btn_press_o[BTN_MID];
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce latency, glitch rejection, bounce, press pulses and repeat.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw_i;
    logic [4:0] btn_level_o;
    logic [4:0] btn_press_o;
    logic       mid_button_o;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw_i   (btn_raw_i),
        .btn_level_o (btn_level_o),
        .btn_press_o (btn_press_o),
        .mid_button_o(mid_button_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        btn_raw_i = '0;
        for (int t = 0; t < 12; t++) tick();
    endtask

    task automatic test_reset();
        logic [4:0] el, ep;
        for (int t = 1; t <= 3; t++) begin
            tick();
            n_checks++;
            if ({btn_level_o, btn_press_o, mid_button_o} !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_hold t=%0d: got lvl=%b prs=%b mid=%b, expected all 0", t, btn_level_o, btn_press_o, mid_button_o);
            end
        end
        rst = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            el = (t >= 6) ? 5'b11111 : 5'b00000;
            ep = (t == 6) ? 5'b11111 : 5'b00000;
            n_checks++;
            if (btn_level_o !== el || btn_press_o !== ep || mid_button_o !== ep[4]) begin
                n_fail++;
                $display("FAIL held_through_reset t=%0d: got lvl=%b prs=%b mid=%b, expected lvl=%b prs=%b", t, btn_level_o, btn_press_o, mid_button_o, el, ep);
            end
        end
        rst = 1'b1;
        #2;
        n_checks++;
        if (btn_level_o !== 5'b00000) begin
            n_fail++;
            $display("FAIL async_reset: got lvl=%b, expected 00000", btn_level_o);
        end
        tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_mid_press();
        logic el, ep;
        btn_raw_i = 5'b10000;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 10) btn_raw_i = 5'b00000;
            el = (t >= 6 && t <= 15);
            ep = (t == 6);
            n_checks++;
            if (btn_level_o !== {el, 4'b0} || btn_press_o !== {ep, 4'b0} || mid_button_o !== ep) begin
                n_fail++;
                $display("FAIL mid_press t=%0d: got lvl=%b prs=%b mid=%b, expected lvl=%b prs=%b", t, btn_level_o, btn_press_o, mid_button_o, {el, 4'b0}, {ep, 4'b0});
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        btn_raw_i[BTN_UP] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 3) btn_raw_i = 5'b00000;
            n_checks++;
            if (btn_level_o !== 5'b0 || btn_press_o !== 5'b0) begin
                n_fail++;
                $display("FAIL glitch t=%0d: got lvl=%b prs=%b, expected 00000 00000", t, btn_level_o, btn_press_o);
            end
        end
        settle();
    endtask

    task automatic test_bounce();
        logic el, ep;
        btn_raw_i[BTN_LEFT] = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (t <= 4) btn_raw_i[BTN_LEFT] = ~btn_raw_i[BTN_LEFT];
            el = (t >= 10);
            ep = (t == 10);
            n_checks++;
            if (btn_level_o !== {2'b0, el, 2'b0} || btn_press_o !== {2'b0, ep, 2'b0}) begin
                n_fail++;
                $display("FAIL bounce t=%0d: got lvl=%b prs=%b, expected lvl=%b prs=%b", t, btn_level_o, btn_press_o, {2'b0, el, 2'b0}, {2'b0, ep, 2'b0});
            end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        logic [4:0] ep;
        btn_raw_i = 5'b10001;
        for (int t = 1; t <= 9; t++) begin
            tick();
            ep = (t == 6) ? 5'b10001 : 5'b00000;
            n_checks++;
            if (btn_press_o !== ep || mid_button_o !== ep[4]) begin
                n_fail++;
                $display("FAIL simultaneous t=%0d: got prs=%b mid=%b, expected prs=%b", t, btn_press_o, mid_button_o, ep);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_count();
        btn_raw_i[BTN_UP] = 1'b1;
        for (int t = 0; t < 4; t++) tick();
        btn_raw_i = 5'b00000;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            n_checks++;
            if (btn_level_o !== 5'b0 || btn_press_o !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_mid_count t=%0d: got lvl=%b prs=%b, expected 00000 00000", t, btn_level_o, btn_press_o);
            end
        end
        settle();
    endtask

    task automatic test_repeat();
        logic ep;
        btn_raw_i[BTN_RIGHT] = 1'b1;
        for (int t = 1; t <= 28; t++) begin
            tick();
            if (t == 20) btn_raw_i = 5'b00000;
`ifdef BTN_REPEAT_EN
            ep = (t == 6 || t == 14 || t == 17 || t == 20 || t == 23);
`else
            ep = (t == 6);
`endif
            n_checks++;
            if (btn_press_o !== {1'b0, ep, 3'b0} || btn_level_o[BTN_RIGHT] !== (t >= 6 && t <= 25)) begin
                n_fail++;
                $display("FAIL repeat_right t=%0d: got lvl=%b prs=%b, expected prs=%b", t, btn_level_o, btn_press_o, {1'b0, ep, 3'b0});
            end
        end
        settle();
        btn_raw_i[BTN_MID] = 1'b1;
        for (int t = 1; t <= 28; t++) begin
            tick();
            if (t == 20) btn_raw_i = 5'b00000;
            ep = (t == 6);
            n_checks++;
            if (btn_press_o !== {ep, 4'b0} || mid_button_o !== ep) begin
                n_fail++;
                $display("FAIL repeat_mid t=%0d: got prs=%b mid=%b, expected prs=%b", t, btn_press_o, mid_button_o, {ep, 4'b0});
            end
        end
        settle();
    endtask

    initial begin
        rst       = 1'b1;
        btn_raw_i = 5'b11111;
        test_reset();
        test_mid_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end for the five-way board buttons: up, down, left, right, mid.
- Synchronises each raw pin, debounces it, and emits a clean one-cycle press pulse per button.
- Sits directly upstream of screen_machine; mid_button_o drives screen_machine's mid_button_i.
- Direction pulses feed the cursor/play logic.

Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required before the debounced level changes (10 ms at 100 MHz).
- SYNC_STAGES, default 2: synchroniser flop depth; minimum 2.
- REPEAT_DELAY, default 50000000: cycles from the press pulse to the first auto-repeat pulse. Used only with BTN_REPEAT_EN.
- REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses. Used only with BTN_REPEAT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- btn_raw_i  in  5  raw active-high pins; index 0=up, 1=down, 2=left, 3=right, 4=mid.
- btn_level_o  out  5  debounced level per button.
- btn_press_o  out  5  one-cycle press pulse per button.
- mid_button_o  out  1  equals btn_press_o[4]; connects to screen_machine.

Behaviour:
- Reset: all sync flops, counters, btn_level_o, btn_press_o and mid_button_o are 0 immediately, asynchronously. Repeat timers are cleared.
- Sync: each pin passes through a SYNC_STAGES flop chain. Only the last stage (syncd) is used downstream.
- Debounce, per button, fully independent of the other buttons:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - When syncd equals btn_level_o, the counter clears to 0.
  - When syncd differs from btn_level_o, the counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, btn_level_o toggles and the counter clears.
- Latency:
  - Raw value first sampled at edge k and held stable: btn_level_o shows the new value after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - With SYNC_STAGES=2 and DEBOUNCE_CYCLES=4, that is 5 cycles after first sampling.
- Press pulse:
  - btn_press_o[i] is registered and is 1 exactly in the cycle where btn_level_o[i] first reads 1.
  - The release edge (level 1->0) produces no pulse.
- Glitch: any excursion shorter than DEBOUNCE_CYCLES consecutive cycles leaves the level unchanged and produces no pulse.
- Bounce: a return to the stable value restarts the count from 0.
- Simultaneous presses: each button pulses independently. Pulses in the same cycle are allowed.
- Held through reset: after rst deasserts, a button still held debounces normally and produces exactly one press pulse.
- Reset mid-count: the counter is discarded and no pulse is emitted.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined: for direction buttons 0..3 only, while btn_level_o[i] stays 1:
  - first extra pulse REPEAT_DELAY cycles after the press pulse;
  - further pulses every REPEAT_PERIOD cycles;
  - the repeat timer clears when the level falls.
- Mid (index 4) never repeats, so screen_machine sees one event per physical press.
- Not defined: exactly one pulse per press on every button. REPEAT_* are ignored and no repeat timer logic is generated.

Decomposition:
- parameter.v (shared include) gains:
  - BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_MID=4;
  - BTN_NUM=5;
  - default DEBOUNCE_CYCLES / REPEAT_* constants.
- One sub-module: button_debounce_cell. It contains synchroniser, counter, level, press pulse and, under macro, the repeat timer, with an input selecting whether repeat is allowed. It is instantiated BTN_NUM times.

Test Plan (sim params DEBOUNCE_CYCLES=4, SYNC_STAGES=2, PERIOD=10):
1. rst=1 with btn_raw_i=5'b11111 -> all outputs 0 throughout reset. After release, each level rises 5 cycles later with a single press pulse per button.
2. Mid held 10 cycles then released -> btn_level_o[4] rises 5 cycles after first sampling; mid_button_o high exactly 1 cycle; level falls 5 cycles after release; no second pulse.
3. Up raw high for 3 cycles only -> btn_level_o and btn_press_o stay 0.
4. Left bounces 1,0,1,0,1 each cycle, then stays 1 -> exactly one btn_press_o[2] pulse, 5 cycles after the final stable sample.
5. Up and mid raised on the same edge -> btn_press_o=5'b10001 in a single cycle.
6. BTN_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3, right held 20 cycles -> pulses at press, +8, +11, +14, +17. Mid held 20 cycles -> one pulse only.
